// File: rtl/keccak_sponge_ctrl.sv
// keccak_sponge_ctrl: sequences clear/absorb/permute/squeeze for the 1600-bit Keccak state datapath
module keccak_sponge_ctrl #(
   parameter int ROUNDS     = 24,
   parameter int RATE_WORDS = 21,
   parameter int IDX_W      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   input  logic             out_ready,
   output logic             out_valid,
   input  logic             more_out,
   output logic             state_en,
   output logic [1:0]       state_sel,
   output logic [IDX_W-1:0] word_idx,
   output logic [IDX_W-1:0] round_idx,
   output logic             busy,
   output logic             perm_done
);
   typedef enum logic [1:0] {IDLE, ABSORB, PERMUTE, SQUEEZE} state_t;
   localparam logic [IDX_W-1:0] W_MAX = IDX_W'(RATE_WORDS - 1);
   localparam logic [IDX_W-1:0] R_MAX = IDX_W'(ROUNDS - 1);
   state_t           state, state_n;
   logic [IDX_W-1:0] word_n, round_n;
   logic             last_blk, last_n, perm_n;
   logic             in_xfer, out_xfer;
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         word_idx  <= '0;
         round_idx <= '0;
         last_blk  <= 1'b0;
         perm_done <= 1'b0;
      end else begin
         state     <= state_n;
         word_idx  <= word_n;
         round_idx <= round_n;
         last_blk  <= last_n;
         perm_done <= perm_n;
      end
   end
   // init wins over every state, so an abandoned permutation never raises perm_done
   always_comb begin
      state_n = state;
      word_n  = word_idx;
      round_n = round_idx;
      last_n  = last_blk;
      perm_n  = 1'b0;
      if (init) begin
         state_n = ABSORB;
         word_n  = '0;
         round_n = '0;
         last_n  = 1'b0;
      end else begin
         case (state)
            ABSORB: if (in_xfer) begin
               if (in_last || word_idx == W_MAX) begin
                  state_n = PERMUTE;
                  word_n  = '0;
                  round_n = '0;
                  last_n  = in_last;
               end else word_n = word_idx + 1'b1;
            end
            PERMUTE: if (round_idx == R_MAX) begin
               state_n = last_blk ? SQUEEZE : ABSORB;
               round_n = '0;
               word_n  = '0;
               perm_n  = 1'b1;
            end else round_n = round_idx + 1'b1;
            SQUEEZE: if (out_xfer) begin
               if (word_idx == W_MAX) begin
                  state_n = more_out ? PERMUTE : IDLE;
                  word_n  = '0;
                  round_n = '0;
               end else word_n = word_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end
   always_comb begin
      in_ready  = (state == ABSORB) & ~init;
      out_valid = (state == SQUEEZE) & ~init;
      state_en  = init | (state == PERMUTE) | in_xfer;
      state_sel = init ? 2'b01 : (state == PERMUTE) ? 2'b11 : in_xfer ? 2'b10 : 2'b00;
      busy      = state != IDLE;
   end
endmodule

// File: tb/tb_keccak_sponge_ctrl.sv
// tb_keccak_sponge_ctrl: directed vector table plus hand sequences for the sponge controller
module tb_keccak_sponge_ctrl;
   logic       clk = 1'b0;
   logic       rst, init, in_valid, in_last, out_ready, more_out;
   logic       in_ready, out_valid, state_en, busy, perm_done;
   logic [1:0] state_sel;
   logic [4:0] word_idx, round_idx;

   keccak_sponge_ctrl #(.ROUNDS(24), .RATE_WORDS(21), .IDX_W(5)) dut (
      .clk(clk), .rst(rst), .init(init), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_ready(out_ready), .out_valid(out_valid), .more_out(more_out),
      .state_en(state_en), .state_sel(state_sel), .word_idx(word_idx), .round_idx(round_idx),
      .busy(busy), .perm_done(perm_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        init, iv, il, ordy, more;
      logic [16:0] exp;
   } vec_t;

   vec_t q[$];
   int   nvec = 0;
   int   nfail = 0;

   // expected {busy,in_ready,out_valid,state_en,state_sel,word_idx,round_idx,perm_done}
   function automatic logic [16:0] e(bit b, bit ir, bit ov, bit en, bit [1:0] sel, int w, int r, bit pd);
      return {b, ir, ov, en, sel, 5'(w), 5'(r), pd};
   endfunction

   function automatic void add(bit ini, bit iv, bit il, bit ordy, bit more, logic [16:0] x);
      vec_t v;
      v.init = ini; v.iv = iv; v.il = il; v.ordy = ordy; v.more = more; v.exp = x;
      q.push_back(v);
   endfunction

   function automatic logic [16:0] act();
      return {busy, in_ready, out_valid, state_en, state_sel, word_idx, round_idx, perm_done};
   endfunction

   task automatic cmp(input string name, input logic [31:0] a, input logic [31:0] x);
      nvec++;
      if (a !== x) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, a, x);
      end
   endtask

   task automatic perm24(bit iv);
      for (int r = 0; r < 24; r++) add(0, iv, 0, 0, 0, e(1, 0, 0, 1, 3, 0, r, 0));
   endtask

   initial begin
      int n, cnt, guard;
      rst = 1; init = 0; in_valid = 1; in_last = 0; out_ready = 0; more_out = 0;
      // single full block, squeeze with continuation, then squeeze with backpressure to IDLE
      add(0, 0, 0, 0, 0, e(0, 0, 0, 0, 0, 0, 0, 0));
      add(1, 0, 0, 0, 0, e(0, 0, 0, 1, 1, 0, 0, 0));
      for (int i = 0; i < 21; i++) add(0, 1, i == 20, 0, 0, e(1, 1, 0, 1, 2, i, 0, 0));
      perm24(0);
      for (int i = 0; i < 21; i++) add(0, 0, 0, 1, i == 20, e(1, 0, 1, 0, 0, i, 0, i == 0));
      perm24(1);
      for (int k = 0; k < 42; k++) add(0, 0, 0, k % 2, 0, e(1, 0, 1, 0, 0, k / 2, 0, k == 0));
      add(0, 1, 0, 1, 0, e(0, 0, 0, 0, 0, 0, 0, 0));
      // two-block message, first block with stalls (in_last without in_valid is ignored)
      add(1, 0, 0, 0, 0, e(0, 0, 0, 1, 1, 0, 0, 0));
      for (int i = 0; i < 21; i++) begin
         add(0, 1, 0, 0, 0, e(1, 1, 0, 1, 2, i, 0, 0));
         if (i < 20) repeat (2) add(0, 0, 1, 0, 0, e(1, 1, 0, 0, 0, i + 1, 0, 0));
      end
      perm24(0);
      add(0, 0, 0, 0, 0, e(1, 1, 0, 0, 0, 0, 0, 1));
      for (int i = 0; i < 4; i++) add(0, 1, i == 3, 0, 0, e(1, 1, 0, 1, 2, i, 0, 0));
      perm24(0);
      add(0, 0, 0, 0, 0, e(1, 0, 1, 0, 0, 0, 0, 1));
      add(0, 0, 0, 1, 0, e(1, 0, 1, 0, 0, 0, 0, 0));
      // init during squeeze, then init colliding with in_valid in ABSORB
      add(1, 0, 0, 1, 0, e(1, 0, 0, 1, 1, 1, 0, 0));
      add(0, 0, 0, 0, 0, e(1, 1, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, e(1, 1, 0, 1, 2, i, 0, 0));
      add(1, 1, 0, 0, 0, e(1, 0, 0, 1, 1, 5, 0, 0));
      add(0, 0, 0, 0, 0, e(1, 1, 0, 0, 0, 0, 0, 0));
      // one-word block, init at round 10, no perm_done afterwards
      add(0, 1, 1, 0, 0, e(1, 1, 0, 1, 2, 0, 0, 0));
      for (int r = 0; r <= 10; r++)
         add(r == 10, 0, 0, 0, 0, r == 10 ? e(1, 0, 0, 1, 1, 0, 10, 0) : e(1, 0, 0, 1, 3, 0, r, 0));
      for (int k = 0; k < 20; k++) add(0, 0, 0, 0, 0, e(1, 1, 0, 0, 0, 0, 0, 0));

      repeat (2) @(posedge clk);
      @(negedge clk);
      cmp("reset", 32'(act()), 32'(e(0, 0, 0, 0, 0, 0, 0, 0)));
      rst = 0; in_valid = 0;

      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         init = q[i].init; in_valid = q[i].iv; in_last = q[i].il;
         out_ready = q[i].ordy; more_out = q[i].more;
         #1;
         cmp($sformatf("vec%0d", i), 32'(act()), 32'(q[i].exp));
      end

      // hand sequence: full block, measured permutation length, random-backpressure squeeze
      @(negedge clk);
      init = 1; in_valid = 0; in_last = 0; out_ready = 0; more_out = 0;
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         init = 0; in_valid = 1; in_last = (i == 20);
      end
      @(negedge clk);
      in_valid = 0; in_last = 0;
      #1;
      n = 0;
      while (!out_valid && n < 40) begin
         n++;
         @(negedge clk);
         #1;
      end
      cmp("perm_cycles", n, 24);
      cnt = 0; guard = 0;
      while (cnt < 21 && guard < 400) begin
         out_ready = 1'($urandom_range(0, 1));
         #1;
         cmp("sq_word", {26'd0, out_valid, word_idx}, {26'd0, 1'b1, 5'(cnt)});
         if (out_ready) cnt++;
         @(negedge clk);
         #1;
         guard++;
      end
      cmp("sq_count", cnt, 21);
      out_ready = 0;
      cmp("sq_idle", {busy, out_valid, word_idx}, 7'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule

// File: doc/keccak_sponge_ctrl.md
Name: keccak_sponge_ctrl

Overview:
Sequencing controller for the 1600-bit Keccak state register and its round/absorb datapath in the SHAKE/SHA3 core. It drives the state register enable and input-mux select, and walks the sponge through clear, absorb, permute and squeeze. It exposes valid/ready handshakes to the message feeder and the output consumer. It holds no state data itself; the lane index and round index it produces address the external datapath.

Parameters:
ROUNDS, 24, Keccak-f rounds per permutation (1..31)
RATE_WORDS, 21, 64-bit lanes per rate block (21 = SHAKE128, 17 = SHAKE256; 1..25)
IDX_W, 5, width of word_idx and round_idx

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
init  in  1  start a new hash; clears the state; overrides everything except rst
in_valid  in  1  absorb word valid
in_last  in  1  with in_valid: final word of final (pre-padded) block
in_ready  out  1  absorb word accepted when in_valid & in_ready
out_ready  in  1  consumer accepts a squeezed word
out_valid  out  1  squeezed lane word_idx is available
more_out  in  1  sampled on the last squeeze word of a block: 1 = squeeze another block
state_en  out  1  state register load enable
state_sel  out  2  00 hold, 01 clear, 10 absorb-XOR lane word_idx, 11 apply round round_idx
word_idx  out  IDX_W  current rate lane (registered)
round_idx  out  IDX_W  current round (registered)
busy  out  1  FSM not in IDLE
perm_done  out  1  one-cycle pulse after the final round of every permutation

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high. On rst: FSM goes to IDLE; word_idx, round_idx, last_blk and perm_done are 0.
- In IDLE: in_ready=0, out_valid=0, state_en=0, state_sel=00, busy=0.
- state_en, state_sel, in_ready and out_valid are combinational decodes of the FSM state, init and the handshakes. All other outputs are registered.
- init (any state, including IDLE):
  - That cycle: state_en=1, state_sel=01, in_ready=0, out_valid=0.
  - Next cycle: FSM in ABSORB, word_idx=0, round_idx=0, last_blk=0.
  - Any permutation or squeeze in progress is abandoned and perm_done does not fire.
- ABSORB (no init): in_ready=1.
  - On a transfer: state_en=1, state_sel=10, and word_idx increments.
  - A transfer with in_last=1 or word_idx==RATE_WORDS-1 ends the block. last_blk is set to in_last, word_idx goes to 0, round_idx goes to 0, and the FSM moves to PERMUTE.
  - With no transfer: state_en=0.
  - in_last before lane RATE_WORDS-1 ends the block early; padding is the feeder's responsibility.
- PERMUTE: state_en=1, state_sel=11 every cycle; in_ready=0, out_valid=0.
  - round_idx counts 0..ROUNDS-1, one round per cycle, so a permutation takes exactly ROUNDS cycles.
  - In the cycle with round_idx==ROUNDS-1: round_idx goes to 0, perm_done is set for the next cycle only, and the next state is SQUEEZE if last_blk=1, else ABSORB with word_idx=0.
- SQUEEZE (no init): out_valid=1, state_en=0.
  - word_idx increments only when out_valid & out_ready.
  - A handshake at word_idx==RATE_WORDS-1 resets word_idx to 0. If more_out=1 that cycle, go to PERMUTE with last_blk kept at 1. Otherwise go to IDLE.
- Squeeze truncation: the consumer stops by asserting init or rst. There is no other abort.
- Counters never exceed RATE_WORDS-1 or ROUNDS-1. No wrap-around can escape a state.
- in_valid and out_ready are ignored outside ABSORB and SQUEEZE respectively.

Test Plan:
- Reset: rst=1 for 2 cycles with in_valid=1 and init=0 -> busy=0, in_ready=0, out_valid=0, state_en=0, word_idx=0, round_idx=0, perm_done=0.
- Single full block: init, then 21 back-to-back words with in_last on the 21st.
  - One clear cycle (sel=01).
  - 21 cycles with sel=10 and word_idx 0..20.
  - 24 cycles with sel=11 and round_idx 0..23.
  - perm_done high for exactly 1 cycle, coinciding with the first out_valid=1 at word_idx=0.
- Two-block message: 21 words without in_last -> permute (24 cycles) -> ABSORB with word_idx=0, in_ready=1. Next block with in_last on word 3 -> PERMUTE after 4 transfers -> SQUEEZE.
- Absorb stalls: in_valid toggled 1,0,0,1,... -> word_idx and state_en advance only on accepted cycles. Total accepted count is 21 before PERMUTE.
- Squeeze backpressure and continuation: out_ready random.
  - word_idx advances only on handshakes.
  - more_out=1 at word 20 -> 24 PERMUTE cycles, then SQUEEZE at word_idx=0.
  - more_out=0 at word 20 -> IDLE, busy=0.
- init mid-permutation at round_idx=10 -> that cycle sel=01, state_en=1. Next cycle ABSORB with round_idx=0, word_idx=0. No perm_done pulse. Also check init asserted together with in_valid in ABSORB -> in_ready=0 and sel=01.
